ula_sequenciador: RTL and testbench

Issue-and-writeback controller for the ULA datapath. Accepts 16-bit instructions over a valid/ready handshake, reads two operands from an internal 8×16 register bank, and drives the ULA's `controle`, `operandoA` and `operandoB` inputs. It then captures `resultadoOp`, writes it back, and registers the Z/C/N/O status flags that the ULA itself does not produce. The block sits between the instruction source and the combinational ULA.

---
 rtl/ula_sequenciador.sv | 161 ++++++++++++++++
 tb/tb_ula_sequenciador.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequenciador.sv
// Issue-and-writeback controller for the ULA: decodes an instruction, drives the ULA
// from an 8x16 register bank, writes the result back and keeps the Z/C/N/O flags.
module ula_sequenciador #(
  parameter int bits_palavra  = 16,
  parameter int bits_controle = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [15:0]              instrucao,
  input  logic                     instr_valida,
  output logic                     instr_pronta,
  input  logic                     esc_ext,
  input  logic [2:0]               esc_end,
  input  logic [bits_palavra-1:0]  esc_dado,
  input  logic [2:0]               le_end,
  output logic [bits_palavra-1:0]  le_dado,
  output logic [bits_controle-1:0] controle,
  output logic [bits_palavra-1:0]  operandoA,
  output logic [bits_palavra-1:0]  operandoB,
  input  logic [bits_palavra-1:0]  resultadoOp,
  output logic                     concluido,
  output logic [3:0]               flags
);

  // state   | meaning
  // OCIOSO  | idle, ready to accept an instruction
  // EXEC    | ULA inputs driven, result captured at the next edge
  // ESCRITA | writeback done, concluido pulses
  typedef enum logic [1:0] {OCIOSO, EXEC, ESCRITA} estado_t;

  estado_t estado, prox_estado;

  logic [bits_palavra-1:0] banco [8];
  logic [2:0]              rd_q;
  logic                    aceita;
  logic                    escreve_wb;
  logic [3:0]              flags_prox;

  logic [bits_controle-1:0] op_in;
  logic [2:0]               rd_in, ra_in, rb_in;
  logic                     unused_bits;

  assign op_in       = instrucao[15:11];
  assign rd_in       = instrucao[10:8];
  assign ra_in       = instrucao[7:5];
  assign rb_in       = instrucao[4:2];
  assign unused_bits = ^instrucao[1:0];

  assign le_dado = banco[le_end];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado <= OCIOSO;
    else          estado <= prox_estado;
  end

  always_comb begin
    prox_estado  = estado;
    instr_pronta = 1'b0;
    concluido    = 1'b0;
    aceita       = 1'b0;
    escreve_wb   = 1'b0;
    case (estado)
      OCIOSO: begin
        instr_pronta = 1'b1;
        if (instr_valida) begin
          aceita      = 1'b1;
          prox_estado = EXEC;
        end
      end
      EXEC: begin
        escreve_wb  = 1'b1;
        prox_estado = ESCRITA;
      end
      ESCRITA: begin
        concluido   = 1'b1;
        prox_estado = OCIOSO;
      end
      default: prox_estado = OCIOSO;
    endcase
  end

  // Operands are sampled with non-blocking reads, so a write on the accept edge is not seen.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      controle  <= '0;
      operandoA <= '0;
      operandoB <= '0;
      rd_q      <= '0;
    end else if (aceita) begin
      controle  <= op_in;
      operandoA <= banco[ra_in];
      operandoB <= banco[rb_in];
      rd_q      <= rd_in;
    end
  end

  // Writeback takes priority over the external port on the same address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) banco[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (escreve_wb && (rd_q == 3'(i)))
          banco[i] <= resultadoOp;
        else if (esc_ext && (esc_end == 3'(i)))
          banco[i] <= esc_dado;
      end
    end
  end

  always_comb begin
    logic z, c, n, o;
    logic [bits_palavra:0] a_ext, b_ext;
    a_ext = {1'b0, operandoA};
    b_ext = {1'b0, operandoB};
    z = (resultadoOp == '0);
    n = resultadoOp[bits_palavra-1];
    c = 1'b0;
    o = 1'b0;
    case (controle)
      5'b00000: begin
        c = ((a_ext + b_ext) >> bits_palavra) != '0;
        o = (operandoA[bits_palavra-1] == operandoB[bits_palavra-1]) &&
            (resultadoOp[bits_palavra-1] != operandoA[bits_palavra-1]);
      end
      5'b00001: begin
        c = ((a_ext + b_ext + 1'b1) >> bits_palavra) != '0;
        o = (operandoA[bits_palavra-1] == operandoB[bits_palavra-1]) &&
            (resultadoOp[bits_palavra-1] != operandoA[bits_palavra-1]);
      end
      5'b00011: begin
        c = ((a_ext + 1'b1) >> bits_palavra) != '0;
        o = !operandoA[bits_palavra-1] && resultadoOp[bits_palavra-1];
      end
      5'b00100: begin
        c = a_ext < (b_ext + 1'b1);
        o = (operandoA[bits_palavra-1] != operandoB[bits_palavra-1]) &&
            (resultadoOp[bits_palavra-1] != operandoA[bits_palavra-1]);
      end
      5'b00101: begin
        c = a_ext < b_ext;
        o = (operandoA[bits_palavra-1] != operandoB[bits_palavra-1]) &&
            (resultadoOp[bits_palavra-1] != operandoA[bits_palavra-1]);
      end
      5'b00110: begin
        c = (operandoA == '0);
        o = operandoA[bits_palavra-1] && !resultadoOp[bits_palavra-1];
      end
      5'b01000: c = operandoA[bits_palavra-1];
      5'b01001: c = operandoA[0];
      default: ;
    endcase
    flags_prox = {z, c, n, o};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        flags <= 4'b0000;
    else if (escreve_wb) flags <= flags_prox;
  end

endmodule

// File: tb/tb_ula_sequenciador.sv
// Self-checking bench for ula_sequenciador: directed table, busy-hold and reset
// sequences, then randomized instructions against a register-bank reference model.
module tb_ula_sequenciador;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] instrucao;
  logic        instr_valida;
  logic        instr_pronta;
  logic        esc_ext;
  logic [2:0]  esc_end;
  logic [15:0] esc_dado;
  logic [2:0]  le_end;
  logic [15:0] le_dado;
  logic [4:0]  controle;
  logic [15:0] operandoA, operandoB, resultadoOp;
  logic        concluido;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  logic [15:0] mreg [8];
  logic [3:0]  mflags;

  ula_sequenciador dut (
    .clock(clock), .reset_n(reset_n), .instrucao(instrucao), .instr_valida(instr_valida),
    .instr_pronta(instr_pronta), .esc_ext(esc_ext), .esc_end(esc_end), .esc_dado(esc_dado),
    .le_end(le_end), .le_dado(le_dado), .controle(controle), .operandoA(operandoA),
    .operandoB(operandoB), .resultadoOp(resultadoOp), .concluido(concluido), .flags(flags)
  );

  always #5 clock = ~clock;

  // Environment ULA: combinational result for each op code.
  function automatic logic [15:0] ula_ref(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a + b + 16'd1;
      5'd2:    return a & b;
      5'd3:    return a + 16'd1;
      5'd4:    return a - b - 16'd1;
      5'd5:    return a - b;
      5'd6:    return a - 16'd1;
      5'd7:    return a | b;
      5'd8:    return a << 1;
      5'd9:    return {a[15], a[15:1]};
      5'd10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  assign resultadoOp = ula_ref(controle, operandoA, operandoB);

  function automatic logic [3:0] ref_flags(input logic [4:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] r);
    int ua, ub;
    logic c, o;
    logic [15:0] bp;
    ua = int'(a);
    ub = int'(b);
    c = 1'b0;
    o = 1'b0;
    case (op)
      5'd0: c = (ua + ub) > 65535;
      5'd1: c = (ua + ub + 1) > 65535;
      5'd3: c = (ua + 1) > 65535;
      5'd4: c = ua < (ub + 1);
      5'd5: c = ua < ub;
      5'd6: c = ua < 1;
      5'd8: c = a[15];
      5'd9: c = a[0];
      default: c = 1'b0;
    endcase
    if (op == 5'd0 || op == 5'd1 || op == 5'd3) begin
      bp = (op == 5'd3) ? 16'd1 : b;
      o = (a[15] == bp[15]) && (r[15] != a[15]);
    end else if (op == 5'd4 || op == 5'd5 || op == 5'd6) begin
      bp = (op == 5'd6) ? 16'd1 : b;
      o = (a[15] != bp[15]) && (r[15] != a[15]);
    end
    return {(r == 16'd0), c, r[15], o};
  endfunction

  task automatic chk(input string nome, input logic [15:0] atual, input logic [15:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nome, atual, esperado, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_pronta && n < 20) begin
      tick();
      n++;
    end
    chk("wait_ready_timeout", {15'd0, instr_pronta}, 16'd1);
  endtask

  task automatic wr(input logic [2:0] ad, input logic [15:0] d);
    esc_ext = 1'b1; esc_end = ad; esc_dado = d;
    tick();
    mreg[ad] = d;
    esc_ext = 1'b0;
  endtask

  task automatic run_instr(input logic [15:0] ins,
                           input logic we0, input logic [2:0] wa0, input logic [15:0] wd0,
                           input logic we1, input logic [2:0] wa1, input logic [15:0] wd1);
    logic [4:0]  op;
    logic [2:0]  rd, ra, rb;
    logic [15:0] a, b, res;
    logic [3:0]  flg;
    wait_ready();
    op = ins[15:11]; rd = ins[10:8]; ra = ins[7:5]; rb = ins[4:2];
    a = mreg[ra]; b = mreg[rb];
    instrucao = ins; instr_valida = 1'b1;
    esc_ext = we0; esc_end = wa0; esc_dado = wd0;
    tick();
    if (we0) mreg[wa0] = wd0;
    instr_valida = 1'b0;
    esc_ext = we1; esc_end = wa1; esc_dado = wd1;
    chk("exec_controle", {11'd0, controle}, {11'd0, op});
    chk("exec_operandoA", operandoA, a);
    chk("exec_operandoB", operandoB, b);
    chk("exec_pronta", {15'd0, instr_pronta}, 16'd0);
    chk("exec_concluido", {15'd0, concluido}, 16'd0);
    res = ula_ref(op, a, b);
    flg = ref_flags(op, a, b, res);
    tick();
    if (we1) mreg[wa1] = wd1;
    mreg[rd] = res;
    mflags = flg;
    esc_ext = 1'b0;
    le_end = rd;
    #1;
    chk("wb_result", le_dado, res);
    chk("wb_flags", {12'd0, flags}, {12'd0, flg});
    chk("wb_concluido", {15'd0, concluido}, 16'd1);
    tick();
    chk("after_concluido", {15'd0, concluido}, 16'd0);
    chk("after_pronta", {15'd0, instr_pronta}, 16'd1);
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [15:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t tab [4];

  initial begin
    logic [15:0] ins;
    logic [2:0]  rdr;
    int          n;

    tab[0] = '{16'h0328, 16'h8000, 4'b0011};
    tab[1] = '{16'h2C44, 16'h8002, 4'b0110};
    tab[2] = '{16'h47C0, 16'h0002, 4'b0100};
    tab[3] = '{16'h4FC0, 16'hC000, 4'b0110};

    reset_n = 1'b0; instrucao = '0; instr_valida = 1'b0;
    esc_ext = 1'b0; esc_end = '0; esc_dado = '0; le_end = '0;
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    mflags = '0;
    #23;
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      le_end = 3'(i);
      #1;
      chk("reset_le_dado", le_dado, 16'd0);
    end
    chk("reset_flags", {12'd0, flags}, 16'd0);
    chk("reset_pronta", {15'd0, instr_pronta}, 16'd1);
    chk("reset_controle", {11'd0, controle}, 16'd0);
    chk("reset_concluido", {15'd0, concluido}, 16'd0);

    wr(3'd1, 16'h7FFF);
    wr(3'd2, 16'h0001);
    wr(3'd6, 16'h8001);

    for (int i = 0; i < 4; i++) begin
      run_instr(tab[i].ins, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
      le_end = tab[i].ins[10:8];
      #1;
      chk("table_result", le_dado, tab[i].res);
      chk("table_flags", {12'd0, flags}, {12'd0, tab[i].flg});
    end

    // Busy hold: valid stays high through EXEC/ESCRITA; the XOR is only taken at accept+3.
    wait_ready();
    instrucao = 16'h1820; instr_valida = 1'b1;
    tick();
    mreg[0] = mreg[1] + 16'd1;
    instrucao = 16'h5524;
    chk("busy_first_op", {11'd0, controle}, 16'd3);
    tick();
    chk("busy_concluido", {15'd0, concluido}, 16'd1);
    tick();
    chk("busy_not_taken", {11'd0, controle}, 16'd3);
    chk("busy_pronta", {15'd0, instr_pronta}, 16'd1);
    tick();
    instr_valida = 1'b0;
    chk("busy_xor_op", {11'd0, controle}, 16'd10);
    chk("busy_xor_a", operandoA, 16'h7FFF);
    tick();
    tick();
    mreg[5] = 16'd0;
    mflags = 4'b1000;
    le_end = 3'd5;
    #1;
    chk("xor_result", le_dado, 16'd0);
    chk("xor_flags", {12'd0, flags}, 16'h0008);

    // Same-edge collision: external write to rd during EXEC loses to writeback.
    run_instr(16'h0328, 1'b0, 3'd0, 16'd0, 1'b1, 3'd3, 16'hABCD);
    // External write on the accept edge to an operand: operand keeps the old value.
    run_instr(16'h0A24, 1'b1, 3'd1, 16'h1234, 1'b0, 3'd0, 16'd0);

    for (int k = 0; k < 40; k++) begin
      rdr = 3'($urandom_range(0, 7));
      ins = {5'($urandom_range(0, 31)), rdr, 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 3) == 0) ins[15:11] = 5'($urandom_range(0, 10));
      run_instr(ins,
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? rdr : 3'($urandom_range(0, 7)),
                16'($urandom));
    end

    for (int i = 0; i < 8; i++) begin
      le_end = 3'(i);
      #1;
      chk("bank_final", le_dado, mreg[i]);
    end

    // Reset during EXEC: writeback discarded, no concluido pulse.
    wr(3'd1, 16'h0005);
    wr(3'd2, 16'h0003);
    wait_ready();
    instrucao = 16'h0328; instr_valida = 1'b1;
    tick();
    instr_valida = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_flags", {12'd0, flags}, 16'd0);
    chk("rst_controle", {11'd0, controle}, 16'd0);
    chk("rst_concluido", {15'd0, concluido}, 16'd0);
    tick();
    reset_n = 1'b1;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if (concluido) n++;
      tick();
    end
    chk("rst_no_pulse", 16'(n), 16'd0);
    chk("rst_pronta", {15'd0, instr_pronta}, 16'd1);
    chk("rst_flags_after", {12'd0, flags}, 16'd0);
    le_end = 3'd3;
    #1;
    chk("rst_rd_zero", le_dado, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
